// File: rtl/i2s_capture_multi_if.sv
// Output word stream of the multi-mic I2S receiver: one sample per transfer,
// tagged with channel index and end-of-frame.
interface i2s_capture_multi_if #(
    parameter int SAMPLE_W = 24,
    parameter int CHAN_W   = 3
);
    logic                valid;
    logic                ready;
    logic [SAMPLE_W-1:0] data;
    logic [CHAN_W-1:0]   chan;
    logic                last;

    modport master (output valid, data, chan, last, input ready);
    modport slave  (input valid, data, chan, last, output ready);
endinterface

// File: rtl/i2s_capture_multi.sv
// Multi-mic I2S receiver: NUM_MICS sd lines on a shared SCK/WS, frame FIFO, word stream out.
// Optional test pattern source enabled by I2S_CAPTURE_MULTI_TEST_PATTERN_EN.
module i2s_capture_multi #(
    parameter int NUM_MICS   = 4,
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int CHAN_W    = (2*NUM_MICS > 1) ? $clog2(2*NUM_MICS) : 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sck_i,
    input  logic                ws_i,
    input  logic [NUM_MICS-1:0] sd_i,
    input  logic                test_mode_i,
    i2s_capture_multi_if.master out,
    output logic [LVL_W-1:0]    level_o,
    output logic                overrun_o,
    input  logic                ovr_clr_i,
    output logic [15:0]         drop_cnt_o
);
    localparam int NCH     = 2*NUM_MICS;
    localparam int ENTRY_W = NCH*SAMPLE_W;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int BW      = $clog2(SAMPLE_W+1);

    logic [1:0]          sck_m, ws_m;
    logic [NUM_MICS-1:0] sd_m, sd_s;
    logic                sck_d, sck_rise, ws_q, armed;
    logic [BW-1:0]       bit_cnt;
    logic [1:0]          full;
    logic [SAMPLE_W-1:0] shreg [NUM_MICS][2];
    logic                ws_s;

    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]  entry, head;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CHAN_W-1:0]   wc;
    logic                commit, fifo_full, push, drop, xfer, pop, word_last;

    assign ws_s      = ws_m[1];
    assign commit    = sck_rise & ws_q & ~ws_s & full[0] & full[1];
    assign fifo_full = (level_o == LVL_W'(FIFO_DEPTH));
    assign push      = commit & ~fifo_full;
    assign drop      = commit & fifo_full;

`ifdef I2S_CAPTURE_MULTI_TEST_PATTERN_EN
    logic [SAMPLE_W-5:0] frame_cnt;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;
`endif

    always_comb begin
        entry = '0;
        for (int m = 0; m < NUM_MICS; m++) begin
            for (int s = 0; s < 2; s++) begin
                entry[(2*m+s)*SAMPLE_W +: SAMPLE_W] = shreg[m][s];
`ifdef I2S_CAPTURE_MULTI_TEST_PATTERN_EN
                if (test_mode_i)
                    entry[(2*m+s)*SAMPLE_W +: SAMPLE_W] = {frame_cnt, 4'(2*m+s)};
`endif
            end
        end
    end

    // armed blocks capture until a real slot boundary has been seen after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_m    <= '0;
            ws_m     <= '0;
            sd_m     <= '0;
            sd_s     <= '0;
            sck_d    <= 1'b0;
            sck_rise <= 1'b0;
            ws_q     <= 1'b0;
            armed    <= 1'b0;
            bit_cnt  <= '0;
            full     <= '0;
            for (int m = 0; m < NUM_MICS; m++) begin
                shreg[m][0] <= '0;
                shreg[m][1] <= '0;
            end
        end else begin
            sck_m    <= {sck_m[0], sck_i};
            ws_m     <= {ws_m[0], ws_i};
            sd_m     <= sd_i;
            sd_s     <= sd_m;
            sck_d    <= sck_m[1];
            sck_rise <= sck_m[1] & ~sck_d;
            if (sck_rise) begin
                ws_q <= ws_s;
                if (ws_s != ws_q) begin
                    bit_cnt <= '0;
                    armed   <= 1'b1;
                    if (ws_q)
                        full <= '0;
                end else if (armed && bit_cnt < BW'(SAMPLE_W)) begin
                    for (int m = 0; m < NUM_MICS; m++)
                        shreg[m][ws_q] <= {shreg[m][ws_q][SAMPLE_W-2:0], sd_s[m]};
                    bit_cnt <= bit_cnt + BW'(1);
                    if (bit_cnt == BW'(SAMPLE_W-1))
                        full[ws_q] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= entry;
    end

    assign head      = mem[rd_ptr];
    assign word_last = (wc == CHAN_W'(NCH-1));
    assign xfer      = out.valid & out.ready;
    assign pop       = xfer & word_last;

    assign out.valid = (level_o != '0);
    assign out.chan  = wc;
    assign out.last  = out.valid & word_last;
    assign out.data  = out.valid ? head[int'(wc)*SAMPLE_W +: SAMPLE_W] : '0;

    // overrun clear wins over a same-cycle drop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_o    <= '0;
            wc         <= '0;
            overrun_o  <= 1'b0;
            drop_cnt_o <= '0;
`ifdef I2S_CAPTURE_MULTI_TEST_PATTERN_EN
            frame_cnt  <= '0;
`endif
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (xfer)
                wc <= word_last ? '0 : wc + CHAN_W'(1);
            level_o <= level_o + LVL_W'(push) - LVL_W'(pop);
            if (ovr_clr_i) begin
                overrun_o  <= 1'b0;
                drop_cnt_o <= '0;
            end else if (drop) begin
                overrun_o <= 1'b1;
                if (drop_cnt_o != 16'hFFFF)
                    drop_cnt_o <= drop_cnt_o + 16'd1;
            end
`ifdef I2S_CAPTURE_MULTI_TEST_PATTERN_EN
            if (commit)
                frame_cnt <= frame_cnt + (SAMPLE_W-4)'(1);
`endif
        end
    end
endmodule

// File: tb/tb_i2s_capture_multi.sv
// Scoreboard bench for i2s_capture_multi: I2S frames are synthesised per slot, expected
// words queued at commit time, and a negedge monitor checks every transfer and stall.
module tb_i2s_capture_multi;
    localparam int NUM_MICS   = 4;
    localparam int SAMPLE_W   = 24;
    localparam int SLOT_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int NCH        = 2*NUM_MICS;
    localparam int CHAN_W     = 3;
    localparam int LVL_W      = 3;

    typedef struct {
        logic [SAMPLE_W-1:0] data;
        logic [CHAN_W-1:0]   chan;
        logic                last;
    } word_t;

    logic clk = 1'b0, rst = 1'b1, sck = 1'b0, ws = 1'b0, test_mode = 1'b0, ovr_clr = 1'b0;
    logic [NUM_MICS-1:0] sd = '0;
    logic [LVL_W-1:0]    level;
    logic                overrun;
    logic [15:0]         drop_cnt;
    int                  ready_mode = 0;

    i2s_capture_multi_if #(.SAMPLE_W(SAMPLE_W), .CHAN_W(CHAN_W)) out_if ();

    i2s_capture_multi #(.NUM_MICS(NUM_MICS), .SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W),
                        .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_i(sd),
        .test_mode_i(test_mode), .out(out_if), .level_o(level), .overrun_o(overrun),
        .ovr_clr_i(ovr_clr), .drop_cnt_o(drop_cnt));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_if.ready = 1'b0;
            1:       out_if.ready = 1'b1;
            default: out_if.ready = 1'($urandom_range(0, 1));
        endcase
    end

    int checks = 0, errors = 0;
    word_t sb[$];
    int model_level = 0;
    logic [15:0] model_drops = '0;
    logic model_ovr = 1'b0;
    logic [SAMPLE_W-1:0] fbuf [NCH];
    logic [SAMPLE_W-1:0] pend [NCH];
    bit pend_valid = 0;
    bit trail_ones = 0;
    logic last_ws = 1'b0;
    logic [SAMPLE_W-5:0] model_fcnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_level = 0;
        model_drops = '0;
        model_ovr   = 1'b0;
        pend_valid  = 0;
        last_ws     = 1'b0;
        model_fcnt  = '0;
    endtask

    // A complete frame is committed when the right slot ends and a new left slot starts
    task automatic model_commit();
        word_t w;
        if (model_level >= FIFO_DEPTH) begin
            model_ovr = 1'b1;
            if (model_drops != 16'hFFFF) model_drops++;
        end else begin
            model_level++;
            for (int c = 0; c < NCH; c++) begin
                w.data = pend[c];
                if (test_mode) w.data = {model_fcnt[SAMPLE_W-5:0], 4'(c)};
                w.chan = CHAN_W'(c);
                w.last = (c == NCH-1);
                sb.push_back(w);
            end
        end
        model_fcnt++;
        pend_valid = 0;
    endtask

    task automatic sck_bit(input logic w, input logic [NUM_MICS-1:0] d);
        ws = w;
        sd = d;
        wclk(4);
        if (w == 1'b0 && last_ws == 1'b1 && pend_valid) model_commit();
        last_ws = w;
        sck = 1'b1;
        wclk(4);
        sck = 1'b0;
    endtask

    task automatic send_frame();
        logic [NUM_MICS-1:0] d;
        for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < SLOT_W; b++) begin
                for (int m = 0; m < NUM_MICS; m++) begin
                    if (b == 0)              d[m] = 1'($urandom_range(0, 1));
                    else if (b <= SAMPLE_W)  d[m] = fbuf[2*m+s][SAMPLE_W-b];
                    else                     d[m] = trail_ones ? 1'b1 : 1'($urandom_range(0, 1));
                end
                sck_bit(1'(s), d);
            end
        end
        pend = fbuf;
        pend_valid = 1;
    endtask

    task automatic rand_frame();
        for (int c = 0; c < NCH; c++) fbuf[c] = SAMPLE_W'($urandom);
        send_frame();
    endtask

    task automatic tail();
        sck_bit(1'b0, NUM_MICS'($urandom));
        sck_bit(1'b1, NUM_MICS'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && sb.size() > 0; i++) wclk(1);
        wclk(4);
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor: every transfer is matched against the scoreboard; stalled words must hold
    logic prev_stall = 1'b0;
    logic [31:0] prev_word = '0;
    always @(negedge clk) begin
        word_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {out_if.valid, out_if.last, 3'(out_if.chan), 3'b0, out_if.data},
                    prev_word);
            if (out_if.valid && out_if.ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual chan=%0d data=%h required none",
                             out_if.chan, out_if.data);
                end else begin
                    e = sb.pop_front();
                    chk("word_data", out_if.data, e.data);
                    chk("word_chan", out_if.chan, e.chan);
                    chk("word_last", out_if.last, e.last);
                    if (e.last) model_level--;
                end
            end
            prev_stall = out_if.valid & ~out_if.ready;
            prev_word  = {out_if.valid, out_if.last, 3'(out_if.chan), 3'b0, out_if.data};
        end
    end

    initial begin
        ready_mode = 0;
        rst = 1'b1;
        wclk(3);
        chk("rst_valid", out_if.valid, 0);
        chk("rst_data", out_if.data, 0);
        chk("rst_chan", out_if.chan, 0);
        chk("rst_last", out_if.last, 0);
        chk("rst_level", level, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        model_reset();

        // directed frame, then full-scale samples with trailing ones in every slot
        ready_mode = 1;
        sck_bit(1'b1, '0);
        for (int m = 0; m < NUM_MICS; m++) begin
            fbuf[2*m]   = SAMPLE_W'(32'h100000 + m);
            fbuf[2*m+1] = SAMPLE_W'(32'h200000 + m);
        end
        send_frame();
        for (int c = 0; c < NCH; c++) fbuf[c] = 24'h7FFFFF;
        trail_ones = 1;
        send_frame();
        trail_ones = 0;
        tail();
        drain();

        // reset, then start in the middle of a right slot
        rst = 1'b1;
        wclk(2);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) sck_bit(1'b1, NUM_MICS'($urandom));
        rand_frame();
        chk("partial_level", level, 0);
        chk("partial_drop_cnt", drop_cnt, 0);
        tail();
        drain();

        // consumer stalled: FIFO fills, later frames dropped
        ready_mode = 0;
        for (int f = 0; f < 6; f++) rand_frame();
        tail();
        wclk(10);
        chk("stall_level", level, FIFO_DEPTH);
        chk("stall_overrun", overrun, 1);
        chk("stall_drop_cnt", drop_cnt, model_drops);
        ready_mode = 1;
        drain();

        // random backpressure
        ready_mode = 2;
        for (int f = 0; f < 20; f++) rand_frame();
        tail();
        drain();
        ready_mode = 1;
        chk("sticky_overrun", overrun, model_ovr);
        chk("sticky_drop_cnt", drop_cnt, model_drops);
        ovr_clr = 1'b1;
        wclk(1);
        ovr_clr = 1'b0;
        model_ovr = 1'b0;
        model_drops = '0;
        wclk(1);
        chk("clr_overrun", overrun, model_ovr);
        chk("clr_drop_cnt", drop_cnt, model_drops);

`ifdef I2S_CAPTURE_MULTI_TEST_PATTERN_EN
        rst = 1'b1;
        wclk(2);
        rst = 1'b0;
        model_reset();
        test_mode = 1'b1;
        sck_bit(1'b1, '0);
        rand_frame();
        rand_frame();
        tail();
        drain();
        test_mode = 1'b0;
`endif

        chk("final_level", level, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_capture_multi.md
# i2s_capture_multi

Multi-microphone I2S receiver, the parametrised successor to the single-line 24-bit capture block. It samples NUM_MICS serial data lines sharing one SCK/WS pair, driven by the existing I2S clock generator. Completed stereo frames are buffered in a frame FIFO, then emitted as a valid/ready word stream tagged with channel index and end-of-frame. It feeds the VU meter and DSP path and reports overrun status to the register bank.

## Interface
- NUM_MICS, 4, number of sd lines (1..8)
- SAMPLE_W, 24, captured bits per slot, MSB-first (8..32)
- SLOT_W, 32, SCK cycles per WS half-period; requires SLOT_W >= SAMPLE_W
- FIFO_DEPTH, 4, frame entries; power of two, >= 2
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- sck_i  in  1  I2S bit clock (asynchronous, oversampled)
- ws_i  in  1  I2S word select; 0 = left, 1 = right
- sd_i  in  NUM_MICS  serial data, one line per mic
- test_mode_i  in  1  selects the test pattern (see Configuration)
- out_valid_o  out  1  word available
- out_ready_i  in  1  consumer accepts word
- out_data_o  out  SAMPLE_W  sample, two's complement as received
- out_chan_o  out  $clog2(2*NUM_MICS) (min 1)  channel = 2*mic + (right ? 1 : 0)
- out_last_o  out  1  last word of frame
- level_o  out  $clog2(FIFO_DEPTH)+1  frames stored
- overrun_o  out  1  sticky; set on dropped frame
- ovr_clr_i  in  1  clears overrun_o and drop_cnt_o
- drop_cnt_o  out  16  dropped frames, saturating at 0xFFFF

## Operation
- Input sync: sck_i, ws_i and sd_i each pass through 2-FF synchronisers. A registered rising-edge detector on the synced SCK produces a one-cycle sck_rise pulse.
- On each sck_rise, the block samples ws_s and sd_s and compares ws_s with the previously sampled ws (ws_q).
  - ws_s != ws_q: slot boundary. bit_cnt <= 0 and the slot becomes the one selected by ws_s. The sd bit sampled on this edge is ignored (it is the last bit of the old slot).
  - otherwise, if bit_cnt < SAMPLE_W: shift the sd bit of every mic into that mic's slot shift register, MSB first, and increment bit_cnt. When bit_cnt reaches SAMPLE_W, set the slot's full flag.
  - bits beyond SAMPLE_W (up to SLOT_W) are ignored.
- Frame commit happens on a right-to-left boundary (ws_q=1, ws_s=0) when both the left and right full flags are set. Both flags then clear. A boundary without both flags set (partial frame after reset or glitch) discards the data silently and is not counted as a drop.
- FIFO entry: all 2*NUM_MICS samples, width 2*NUM_MICS*SAMPLE_W.
- Push while full: the frame is dropped, overrun_o <= 1, and drop_cnt_o increments (saturating). Fullness is evaluated on the pre-cycle level, so a push coinciding with the final pop of a full FIFO is still dropped.
- Read side: a word counter walks the head entry in order mic0 L, mic0 R, mic1 L, …, mic(N-1) R. out_last_o = 1 on the final word.
  - A word transfers when out_valid_o & out_ready_i; the counter then advances.
  - The entry pops on transfer of the last word and the counter wraps to 0.
  - Outputs hold stable while out_valid_o & !out_ready_i.
- ovr_clr_i has priority over a same-cycle overrun set: the result is cleared, and the count is 0 (the drop is lost).

## Timing
- Reset values: out_valid_o=0, out_data_o=0, out_chan_o=0, out_last_o=0, level_o=0, overrun_o=0, drop_cnt_o=0. Reset also clears the shift registers, flags, bit_cnt, ws_q (to 0), the FIFO pointers and the word counter.
- Reset mid-frame: the partial frame is lost. The first commit after reset needs a complete left slot followed by a complete right slot.
- sck_rise asserts 3 clk after a rising edge of sck_i (2 sync stages + edge register).
- Commit cycle (the sck_rise cycle with the boundary): the FIFO write occurs at that clock edge, and level_o increments the next cycle. If the FIFO was empty, out_valid_o asserts in the same cycle as the new level_o.
- Throughput: 1 word/clk when out_ready_i is held high.
- Minimum clk_i/SCK ratio: 8.

## Configuration
- Macro I2S_CAPTURE_MULTI_TEST_PATTERN_EN.
- Defined: when test_mode_i=1, the committed sample for channel c is {frame_cnt[SAMPLE_W-5:0], c[3:0]} instead of shifted sd data.
  - frame_cnt is a SAMPLE_W-4 bit counter, reset to 0, incremented per commit attempt (including drops).
  - Slot timing and framing are unchanged.
- Undefined: test_mode_i is ignored and the pattern logic is not synthesised.

## Test plan
- Single frame, NUM_MICS=4: mic m drives L=0x100000+m, R=0x200000+m → 8 words with chan 0..7, data 0x100000, 0x200000, 0x100001, …, last only on chan 7.
- Start mid-right-slot after reset → first partial frame discarded, level_o stays 0, drop_cnt_o=0; first full frame emitted correctly.
- out_ready_i=0, FIFO_DEPTH=4, 6 frames → level_o=4, overrun_o=1, drop_cnt_o=2; after draining, the first 4 frames appear in order.
- Random out_ready_i with 50% duty over 20 frames → no word lost or duplicated, data stable while stalled; then ovr_clr_i pulse → overrun_o=0, drop_cnt_o=0.
- SAMPLE_W=24, SLOT_W=32, sd held 1 on bits 24..31 → data unaffected (0x7FFFFF pattern not corrupted by trailing bits).
- With the macro defined, test_mode_i=1 → frame 0 chan 5 yields 0x000005, frame 1 chan 5 yields 0x000015.
